// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Shared with the receiver's baud tick generator.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 435;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side word handshake into the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;

  modport master (output tx_data, output tx_valid, input tx_ready, input tx_busy);
  modport slave  (input tx_data, input tx_valid, output tx_ready, output tx_busy);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Restartable bit-period divider; bit_end strobes on the last clock of each bit.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign bit_end = (count_q == LAST);

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || bit_end) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx
);
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic             ODD_FLIP  = (PARITY == PARITY_ODD);
  localparam logic             HAS_PAR   = (PARITY != PARITY_NONE);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;
  logic                 timer_clear;

  // Holding the timer clear while idle restarts the bit period at acceptance.
  assign timer_clear = (state_q == IDLE);

  uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;

    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid && ready_q) begin
          shift_d   = bus.tx_data;
          bit_cnt_d = '0;
          parity_d  = (^bus.tx_data) ^ ODD_FLIP;
          state_d   = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = HAS_PAR ? uart_pkg::PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      uart_pkg::PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP) state_d = IDLE;
          else                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so tx stays a plain flop.
    tx_d = 1'b1;
    unique case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = parity_d;
      default:          tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign tx           = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: several parameterisations compared cycle by cycle against a frame model.
module tb_uart_tx;
  localparam int NI = 6;
  localparam int CFG_N [NI] = '{435, 4, 4, 4, 4, 2};
  localparam int CFG_D [NI] = '{8, 8, 8, 8, 8, 9};
  localparam int CFG_P [NI] = '{0, 0, 2, 1, 0, 1};
  localparam int CFG_S [NI] = '{1, 1, 1, 1, 2, 2};

  logic clk;
  logic [NI-1:0] rst_w, vld_w, tx_w, rdy_w, bsy_w;
  logic [8:0] dat_w [NI];
  int n_checks, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx_if #(.DATA_BITS(8)) if3 ();
  uart_tx_if #(.DATA_BITS(8)) if4 ();
  uart_tx_if #(.DATA_BITS(9)) if5 ();

  assign if0.tx_valid = vld_w[0]; assign if0.tx_data = dat_w[0][7:0];
  assign if1.tx_valid = vld_w[1]; assign if1.tx_data = dat_w[1][7:0];
  assign if2.tx_valid = vld_w[2]; assign if2.tx_data = dat_w[2][7:0];
  assign if3.tx_valid = vld_w[3]; assign if3.tx_data = dat_w[3][7:0];
  assign if4.tx_valid = vld_w[4]; assign if4.tx_data = dat_w[4][7:0];
  assign if5.tx_valid = vld_w[5]; assign if5.tx_data = dat_w[5];
  assign rdy_w = {if5.tx_ready, if4.tx_ready, if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};
  assign bsy_w = {if5.tx_busy, if4.tx_busy, if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};

  uart_tx #(.CLKS_PER_BIT(435), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst_w[0]), .bus(if0.slave), .tx(tx_w[0]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst_w[1]), .bus(if1.slave), .tx(tx_w[1]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u2 (.clk(clk), .rst(rst_w[2]), .bus(if2.slave), .tx(tx_w[2]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u3 (.clk(clk), .rst(rst_w[3]), .bus(if3.slave), .tx(tx_w[3]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
    u4 (.clk(clk), .rst(rst_w[4]), .bus(if4.slave), .tx(tx_w[4]));
  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2))
    u5 (.clk(clk), .rst(rst_w[5]), .bus(if5.slave), .tx(tx_w[5]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int idx);
    return 1 + CFG_D[idx] + ((CFG_P[idx] != 0) ? 1 : 0) + CFG_S[idx];
  endfunction

  // Frame as line levels, one entry per bit period; unused tail stays high.
  function automatic logic [15:0] frame_bits(input int idx, input logic [8:0] d);
    logic [15:0] f;
    logic [8:0]  m;
    int ones;
    f = '1;
    m = 9'((1 << CFG_D[idx]) - 1);
    f[0] = 1'b0;
    for (int i = 0; i < CFG_D[idx]; i++) f[1 + i] = d[i];
    ones = $countones(d & m);
    if (CFG_P[idx] == 2) f[1 + CFG_D[idx]] = 1'((ones % 2) == 1);
    if (CFG_P[idx] == 1) f[1 + CFG_D[idx]] = 1'((ones % 2) == 0);
    return f;
  endfunction

  task automatic check_idle(input int idx, input string tag);
    check($sformatf("%s_tx%0d", tag, idx),  32'(tx_w[idx]),  32'd1);
    check($sformatf("%s_rdy%0d", tag, idx), 32'(rdy_w[idx]), 32'd1);
    check($sformatf("%s_bsy%0d", tag, idx), 32'(bsy_w[idx]), 32'd0);
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge of the first idle cycle after the frame.
  task automatic send(input int idx, input logic [8:0] d, input bit hold, input bit poke);
    logic [15:0] f;
    int n, nb;
    f  = frame_bits(idx, d);
    n  = CFG_N[idx];
    nb = frame_len(idx) * n;
    check_idle(idx, "pre");
    vld_w[idx] = 1'b1;
    dat_w[idx] = d;
    @(posedge clk);
    @(negedge clk);
    if (!hold) vld_w[idx] = 1'b0;
    dat_w[idx] = 9'($urandom);
    for (int k = 0; k < nb; k++) begin
      if (poke && k == nb / 2) begin
        vld_w[idx] = 1'b1;
        dat_w[idx] = ~d;
      end
      if (poke && k == nb / 2 + 1) vld_w[idx] = 1'b0;
      check($sformatf("tx%0d_k%0d", idx, k), 32'(tx_w[idx]), 32'(f[k / n]));
      check($sformatf("rdy%0d_k%0d", idx, k), 32'(rdy_w[idx]), 32'd0);
      check($sformatf("bsy%0d_k%0d", idx, k), 32'(bsy_w[idx]), 32'd1);
      @(negedge clk);
    end
    check_idle(idx, "post");
  endtask

  task automatic abort_test(input int idx);
    int n;
    logic [15:0] f;
    n = CFG_N[idx];
    f = frame_bits(idx, 9'h030);
    vld_w[idx] = 1'b1;
    dat_w[idx] = 9'h030;
    @(posedge clk);
    @(negedge clk);
    vld_w[idx] = 1'b0;
    repeat (4 * n + n / 2) @(negedge clk);
    check("abort_bit3", 32'(tx_w[idx]), 32'(f[4]));
    check("abort_bsy", 32'(bsy_w[idx]), 32'd1);
    rst_w[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_w[idx] = 1'b0;
    check_idle(idx, "abort_rst");
    for (int c = 0; c < 3 * n; c++) begin
      @(negedge clk);
      check_idle(idx, "abort_hold");
    end
    send(idx, 9'h0A5, 1'b0, 1'b0);
  endtask

  initial begin
    int d_max;
    logic [8:0] d;
    bit hold;
    n_checks = 0;
    n_fail   = 0;
    rst_w = '1;
    vld_w = '0;
    for (int i = 0; i < NI; i++) dat_w[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle(i, "rst");
    rst_w = '0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle(i, "after_rst");

    send(0, 9'h055, 1'b0, 1'b0);
    send(1, 9'h000, 1'b1, 1'b0);
    send(1, 9'h0FF, 1'b0, 1'b0);
    send(2, 9'h007, 1'b0, 1'b0);
    send(3, 9'h007, 1'b0, 1'b0);
    send(2, 9'h000, 1'b0, 1'b0);
    send(4, 9'($urandom), 1'b0, 1'b0);
    abort_test(1);

    send(1, 9'($urandom_range(0, 255)), 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_idle(1, "no_queue");
    end

    for (int idx = 1; idx < NI; idx++) begin
      d_max = (1 << CFG_D[idx]) - 1;
      for (int r = 0; r < 4; r++) begin
        d    = 9'($urandom_range(0, d_max));
        hold = (r < 3) && ($urandom_range(0, 1) == 1);
        send(idx, d, hold, 1'b0);
        if (!hold) begin
          repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check_idle(idx, "gap");
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter; the transmit-side counterpart of the oversampling receiver. It accepts one parallel word per valid/ready handshake and shifts it out on a single line as a standard asynchronous frame: start bit, data LSB first, optional parity, stop bit(s). An internal bit timer shares the divider scheme used by the baud tick generator (default 435 clocks per bit). It sits between the host-side byte source and the TX pad.

## Interface
- CLKS_PER_BIT, 435: clock cycles per serial bit; must be ≥ 2, elaboration error otherwise.
- DATA_BITS, 8: data bits per frame, legal range 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even; any other value is an elaboration error.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  word to send; sampled only on acceptance.
- tx_valid  in  1  word on tx_data is valid.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- tx  out  1  serial line; idle high.
- tx_busy  out  1  a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx = 1, tx_ready = 1, tx_busy = 0. On tx_valid && tx_ready, latch tx_data into the shift register, clear the bit counter and bit timer, and go to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift[0]. Shift right at each bit end. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, else go to STOP.
- PARITY: tx = XOR of the latched data for even parity, and its inverse for odd parity. Lasts one bit time, then go to STOP.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
- Bit timer counts 0 to CLKS_PER_BIT−1 and has width $clog2(CLKS_PER_BIT). The bit-end strobe fires at count CLKS_PER_BIT−1; the counter wraps to 0 on the strobe.
- tx, tx_ready and tx_busy are registered outputs, with no combinational path from inputs.
- tx_valid while busy is ignored: no acceptance and no side effects. Changes on tx_data after acceptance do not affect the frame.
- Reset values: tx = 1, tx_ready = 1, tx_busy = 0, state = IDLE, timer and counters = 0.
- Reset mid-frame aborts the frame. tx is high in the cycle after the rst edge, and the partial frame is never resumed.

## Timing
- Define F = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS, and N = CLKS_PER_BIT.
- Acceptance at edge T means the start bit drives tx from cycle T+1 through T+N.
- Data bit i is driven during [T+1+(1+i)·N, T+(2+i)·N].
- The last stop cycle is T+F·N. tx_ready and tx_busy deassert at T+1 and reassert at T+F·N+1.
- With tx_valid held high, the next acceptance is at T+F·N+1 and its start bit begins at T+F·N+2. The inter-frame gap is exactly 1 idle-high clock.
- Latency from acceptance to the first start-bit cycle is 1 clock.

## Structure
- Shared package uart_pkg holds:
  - the state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - the parity constants PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2;
  - the default CLKS_PER_BIT = 435 constant, shared with the receiver.
- One sub-module, uart_tx_bit_timer, has the ports clk, rst, clear, and bit_end. It is a resettable, restartable divider producing the bit-end strobe.
- The FSM, shift register and bit counter live in uart_tx.

## Test plan
- Defaults, send 0x55 → tx = 0,1,0,1,0,1,0,1,0,1, each held 435 cycles. tx_ready is low for exactly 4350 cycles.
- CLKS_PER_BIT = 4, tx_valid held with 0x00 then 0xFF → the frames are back-to-back with exactly one idle-high clock between the stop bit and the next start bit.
- PARITY = 2, send 0x07 → parity bit 1. PARITY = 1, send 0x07 → parity bit 0. PARITY = 2, send 0x00 → parity bit 0.
- STOP_BITS = 2, CLKS_PER_BIT = 4 → the stop level is high for 8 cycles, and tx_ready rises at T+F·N+1 with F = 11.
- Assert rst for 1 cycle during data bit 3 → tx = 1 and tx_ready = 1 on the next cycle. A fresh 0xA5 sent afterwards has the correct full timing.
- Change tx_data and pulse tx_valid mid-frame → the transmitted word is unchanged and no second frame is queued.
